// File: rtl/xcore_fetch_redirect_ctrl.sv
// Fetch-PC sequencer: picks the next fetch address from flush, JALR, predictor or PC+4.
// Latency: a redirect sampled at edge N appears on if_pc right after edge N; flush adds FLUSH_BUBBLES invalid cycles.
// Backpressure: if_stall holds PC and state in RUN; JWAIT/BUBBLE ignore it so pulses are never lost.
module xcore_fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FLUSH_BUBBLES = 1
) (
    input  logic        frc_clk,
    input  logic        frc_rst,
    input  logic        ex_flush_valid,
    input  logic [31:0] ex_flush_adr,
    input  logic        bpu_jump_valid,
    input  logic [31:0] bpu_instr_adr,
    input  logic        id_jalr_valid,
    input  logic        ex_jalr_done,
    input  logic [31:0] ex_jalr_adr,
    input  logic        if_stall,
    output logic [31:0] if_pc,
    output logic        if_pc_valid,
    output logic        bpu_flush,
    output logic        bpu_stall,
    output logic [1:0]  frc_state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_JWAIT   = 2'b01,
        ST_BUBBLE  = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    // Fetch addresses are word aligned; low two bits of every redirect are dropped.
    localparam logic [31:0] ADR_MASK = 32'hFFFF_FFFC;
    // Counter value loaded on flush: counts down to 0, then one more cycle before RUN.
    localparam logic [3:0]  BUB_LOAD = (FLUSH_BUBBLES == 0) ? 4'd0 : 4'(FLUSH_BUBBLES - 1);
    localparam state_t      FLUSH_ST = (FLUSH_BUBBLES == 0) ? ST_RUN : ST_BUBBLE;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] flush_pc, jump_pc, jalr_pc;

    assign flush_pc = ex_flush_adr  & ADR_MASK;
    assign jump_pc  = bpu_instr_adr & ADR_MASK;
    assign jalr_pc  = ex_jalr_adr   & ADR_MASK;

    // State, PC and bubble counter registers; reset parks in BUBBLE so RESET_PC is fetched one cycle later.
    always_ff @(posedge frc_clk) begin
        if (frc_rst) begin
            state_q <= ST_BUBBLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-PC selection; a flush wins in every legal state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (ex_flush_valid) begin
                    pc_d    = flush_pc;
                    state_d = FLUSH_ST;
                    cnt_d   = BUB_LOAD;
                end else if (!if_stall) begin
                    if (id_jalr_valid) begin
                        state_d = ST_JWAIT;
                    end else if (bpu_jump_valid) begin
                        pc_d = jump_pc;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            ST_JWAIT: begin
                if (ex_flush_valid) begin
                    pc_d    = flush_pc;
                    state_d = FLUSH_ST;
                    cnt_d   = BUB_LOAD;
                end else if (ex_jalr_done) begin
                    pc_d    = jalr_pc;
                    state_d = ST_RUN;
                end
            end
            ST_BUBBLE: begin
                if (ex_flush_valid) begin
                    pc_d    = flush_pc;
                    state_d = FLUSH_ST;
                    cnt_d   = BUB_LOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign if_pc       = pc_q;
    assign if_pc_valid = (state_q == ST_RUN);
    assign bpu_flush   = ex_flush_valid;
    assign bpu_stall   = if_stall | (state_q != ST_RUN);
    assign frc_state   = state_q;

endmodule

// File: tb/tb_xcore_fetch_redirect_ctrl.sv
// Bench for xcore_fetch_redirect_ctrl: two instances (FLUSH_BUBBLES=2 and 0) share stimulus.
// Each is compared every cycle against a small behavioural model of fetch PC / validity.
// Directed steps from the plan are followed by a randomized stretch.
module tb_xcore_fetch_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        frc_clk;
    logic        frc_rst;
    logic        ex_flush_valid;
    logic [31:0] ex_flush_adr;
    logic        bpu_jump_valid;
    logic [31:0] bpu_instr_adr;
    logic        id_jalr_valid;
    logic        ex_jalr_done;
    logic [31:0] ex_jalr_adr;
    logic        if_stall;

    logic [31:0] o_pc    [2];
    logic        o_vld   [2];
    logic        o_flush [2];
    logic        o_stall [2];
    logic [1:0]  o_state [2];

    int n_cmp = 0;
    int n_mis = 0;

    // Model: PC, whether waiting for a JALR target, and the number of invalid cycles still to come.
    logic [31:0] m_pc   [2];
    bit          m_wait [2];
    int          m_left [2];

    xcore_fetch_redirect_ctrl #(.RESET_PC(RST_PC), .FLUSH_BUBBLES(2)) u_nb2 (
        .frc_clk(frc_clk), .frc_rst(frc_rst),
        .ex_flush_valid(ex_flush_valid), .ex_flush_adr(ex_flush_adr),
        .bpu_jump_valid(bpu_jump_valid), .bpu_instr_adr(bpu_instr_adr),
        .id_jalr_valid(id_jalr_valid), .ex_jalr_done(ex_jalr_done), .ex_jalr_adr(ex_jalr_adr),
        .if_stall(if_stall),
        .if_pc(o_pc[0]), .if_pc_valid(o_vld[0]), .bpu_flush(o_flush[0]),
        .bpu_stall(o_stall[0]), .frc_state(o_state[0])
    );

    xcore_fetch_redirect_ctrl #(.RESET_PC(RST_PC), .FLUSH_BUBBLES(0)) u_nb0 (
        .frc_clk(frc_clk), .frc_rst(frc_rst),
        .ex_flush_valid(ex_flush_valid), .ex_flush_adr(ex_flush_adr),
        .bpu_jump_valid(bpu_jump_valid), .bpu_instr_adr(bpu_instr_adr),
        .id_jalr_valid(id_jalr_valid), .ex_jalr_done(ex_jalr_done), .ex_jalr_adr(ex_jalr_adr),
        .if_stall(if_stall),
        .if_pc(o_pc[1]), .if_pc_valid(o_vld[1]), .bpu_flush(o_flush[1]),
        .bpu_stall(o_stall[1]), .frc_state(o_state[1])
    );

    initial frc_clk = 1'b0;
    always #5 frc_clk = ~frc_clk;

    function automatic int nb(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic bit m_valid(input int i);
        return !m_wait[i] && (m_left[i] == 0);
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s[inst%0d] observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (frc_rst) begin
                m_pc[i] = RST_PC; m_wait[i] = 0; m_left[i] = 1;
            end else if (ex_flush_valid) begin
                m_pc[i] = ex_flush_adr & ~32'h3; m_wait[i] = 0; m_left[i] = nb(i);
            end else if (m_left[i] > 0) begin
                m_left[i]--;
            end else if (m_wait[i]) begin
                if (ex_jalr_done) begin
                    m_pc[i] = ex_jalr_adr & ~32'h3; m_wait[i] = 0;
                end
            end else if (!if_stall) begin
                if (id_jalr_valid)       m_wait[i] = 1;
                else if (bpu_jump_valid) m_pc[i] = bpu_instr_adr & ~32'h3;
                else                     m_pc[i] = m_pc[i] + 32'd4;
            end
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 2; i++) begin
            chk("if_pc", i, o_pc[i], m_pc[i]);
            chk("if_pc_valid", i, 32'(o_vld[i]), 32'(m_valid(i)));
            chk("frc_state", i, 32'(o_state[i]),
                m_wait[i] ? 32'd1 : (m_left[i] > 0 ? 32'd2 : 32'd0));
        end
    endtask

    // Check combinational outputs mid-cycle, clock once, then check registered outputs.
    task automatic step();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("bpu_flush", i, 32'(o_flush[i]), 32'(ex_flush_valid));
            chk("bpu_stall", i, 32'(o_stall[i]), 32'(if_stall | !m_valid(i)));
        end
        @(posedge frc_clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic drive(input bit rst, input bit fl, input logic [31:0] fa, input bit jv,
                         input logic [31:0] ja, input bit jr, input bit jd,
                         input logic [31:0] da, input bit st);
        frc_rst = rst; ex_flush_valid = fl; ex_flush_adr = fa;
        bpu_jump_valid = jv; bpu_instr_adr = ja; id_jalr_valid = jr;
        ex_jalr_done = jd; ex_jalr_adr = da; if_stall = st;
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        frc_rst = 1; ex_flush_valid = 0; ex_flush_adr = 0; bpu_jump_valid = 0;
        bpu_instr_adr = 0; id_jalr_valid = 0; ex_jalr_done = 0; ex_jalr_adr = 0; if_stall = 0;
        @(posedge frc_clk);
        @(posedge frc_clk);
        model_edge();
        #1;
        check_regs();

        // 1: reset release, one invalid cycle, then 0x100, 0x104, 0x108.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // 2: jump to 0x200, then predictor jump to 0x1F0; then a stalled jump holds.
        drive(0, 0, 0, 1, 32'h200, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h1F0, 0, 0, 0, 0);
        idle(1);
        drive(0, 0, 0, 1, 32'h200, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h1F0, 0, 0, 0, 1);
        idle(1);

        // 3: JALR beats jump, wait 5 cycles with distractors, resolve under stall to 0x4003.
        drive(0, 0, 0, 1, 32'h300, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h700, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 1, 32'h900, 1, 0, 0, k[0]);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h4003, 1);
        idle(2);

        // 4: flush to 0x800 alongside a predictor jump.
        drive(0, 1, 32'h800, 1, 32'h1234, 0, 0, 0, 0);
        idle(4);

        // 5: flush restarted during bubble; flush abandons a JALR wait; stale jalr_done ignored.
        drive(0, 1, 32'h800, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h901, 0, 0, 0, 0, 0, 0);
        idle(3);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);
        drive(0, 1, 32'hA00, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h5000, 0);
        idle(3);

        // 6: PC+4 wrap, and reset in the middle of a JALR wait.
        drive(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
        idle(2);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);
        drive(1, 0, 0, 0, 0, 0, 1, 32'h6000, 0);
        idle(3);

        // Randomized stretch.
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 15) == 0), $urandom(),
                  ($urandom_range(0, 3) == 0), $urandom(),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0), $urandom(),
                  ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
